// File: rtl/yolo_fp_pkg.sv
// yolo_fp_pkg: FP32 field layout, special constants and tree sizing shared by the layer blocks.
package yolo_fp_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN            = 32'h7FC00000;
    localparam logic [31:0] ZERO            = 32'h00000000;
    localparam logic [31:0] ONE             = 32'h3F800000;
    localparam logic [31:0] LEAKY_SLOPE_0P1 = 32'h3DCCCCCD;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expn;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic int tree_depth(input int n);
        int d = 0;
        for (int v = 1; v < n; v = v * 2) d++;
        return d;
    endfunction
endpackage

// File: rtl/fp32_add_reg.sv
// fp32_add_reg: FP32 add (round-to-nearest-even, subnormals flushed to signed zero)
// followed by one output register.
module fp32_add_reg
    import yolo_fp_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    fp32_t       fa, fb, big, sml;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sub, swap, rnd;
    logic [7:0]  d;
    logic [50:0] sml_sh;
    logic [26:0] m_big, m_sml, m_n;
    logic [27:0] m_sum;
    logic [4:0]  lz;
    logic [9:0]  e_n;
    logic [32:0] r;
    logic [31:0] y_d, y_q;

    always_comb begin
        fa = a;
        fb = b;
        a_nan = fa.expn == '1 && fa.man != '0;
        b_nan = fb.expn == '1 && fb.man != '0;
        a_inf = fa.expn == '1 && fa.man == '0;
        b_inf = fb.expn == '1 && fb.man == '0;
        a_zero = fa.expn == '0;
        b_zero = fb.expn == '0;
        sub = fa.sign ^ fb.sign;
        swap = {fb.expn, fb.man} > {fa.expn, fa.man};
        big = swap ? fb : fa;
        sml = swap ? fa : fb;
        d = big.expn - sml.expn;
        // 27-bit mantissas: hidden, 23 fraction, guard, round, sticky
        sml_sh = {1'b1, sml.man, 27'b0} >> d;
        m_big = {1'b1, big.man, 3'b0};
        m_sml = d > 8'd50 ? 27'd1 : {sml_sh[50:25], |sml_sh[24:0]};
        m_sum = sub ? {1'b0, m_big - m_sml} : {1'b0, m_big} + {1'b0, m_sml};
        lz = '0;
        for (int i = 0; i < 27; i++) if (m_sum[i]) lz = 5'(26 - i);
        m_n = m_sum[27] ? {m_sum[27:2], |m_sum[1:0]} : m_sum[26:0] << lz;
        e_n = {2'b0, big.expn} + {9'b0, m_sum[27]} - {5'b0, lz};
        rnd = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
        // hidden bit and rounding carry ripple straight into the exponent field
        r = {e_n - 10'd1, 23'b0} + {9'b0, m_n[26:3]} + 33'(rnd);
        y_d = (a_nan || b_nan || (a_inf && b_inf && sub)) ? QNAN
            : a_inf ? a
            : b_inf ? b
            : (a_zero && b_zero) ? {fa.sign & fb.sign, 31'b0}
            : a_zero ? b
            : b_zero ? a
            : m_sum == '0 ? ZERO
            : $signed(r[32:23]) >= 10'sd255 ? {big.sign, 8'hFF, 23'b0}
            : $signed(r[32:23]) <= 10'sd0 ? {big.sign, 31'b0}
            : {big.sign, r[30:0]};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) y_q <= '0;
        else y_q <= y_d;
    end

    assign y = y_q;
endmodule

// File: rtl/fp32_mul_reg.sv
// fp32_mul_reg: FP32 multiply (round-to-nearest-even, subnormals flushed to signed zero)
// followed by one output register.
module fp32_mul_reg
    import yolo_fp_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    fp32_t       fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s, g, st, rnd;
    logic [47:0] p;
    logic [23:0] m24;
    logic [9:0]  e_pre;
    logic [32:0] r;
    logic [31:0] y_d, y_q;

    always_comb begin
        fa = a;
        fb = b;
        a_nan = fa.expn == '1 && fa.man != '0;
        b_nan = fb.expn == '1 && fb.man != '0;
        a_inf = fa.expn == '1 && fa.man == '0;
        b_inf = fb.expn == '1 && fb.man == '0;
        a_zero = fa.expn == '0;
        b_zero = fb.expn == '0;
        s = fa.sign ^ fb.sign;
        p = {1'b1, fa.man} * {1'b1, fb.man};
        m24 = p[47] ? p[47:24] : p[46:23];
        g = p[47] ? p[23] : p[22];
        st = p[47] ? |p[22:0] : |p[21:0];
        rnd = g & (st | m24[0]);
        // exponent carried one low so the hidden bit in m24 restores it
        e_pre = {2'b0, fa.expn} + {2'b0, fb.expn} - 10'(EXP_BIAS + 1) + {9'b0, p[47]};
        r = {e_pre, 23'b0} + {9'b0, m24} + 33'(rnd);
        y_d = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? QNAN
            : (a_inf || b_inf) ? {s, 8'hFF, 23'b0}
            : (a_zero || b_zero) ? {s, 31'b0}
            : $signed(r[32:23]) >= 10'sd255 ? {s, 8'hFF, 23'b0}
            : $signed(r[32:23]) <= 10'sd0 ? {s, 31'b0}
            : {s, r[30:0]};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) y_q <= '0;
        else y_q <= y_d;
    end

    assign y = y_q;
endmodule

// File: rtl/layer_4_featuremap_reduce.sv
// layer_4_featuremap_reduce: sums the per-channel conv partials with a fixed-order adder tree,
// adds the bias, applies leaky ReLU and tags row/frame ends for the pooling stage.
module layer_4_featuremap_reduce
    import yolo_fp_pkg::*;
#(
    parameter int          NUM_CH        = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter int          DATA_IN_WIDTH = NUM_CH * DATA_WIDTH,
    parameter int          IMG_SIZE      = 104,
    parameter logic [31:0] BIAS          = 32'h00000000,
    parameter logic [31:0] LEAKY_SLOPE   = LEAKY_SLOPE_0P1
)(
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_IN_WIDTH-1:0] data_in,
    input  logic                     valid_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    output logic                     row_end,
    output logic                     frame_end
);
    localparam int DEPTH = tree_depth(NUM_CH);
    localparam int LAT   = DEPTH + 2;
    localparam int CW    = $clog2(IMG_SIZE + 1);

    // heap-ordered tree: node[NUM_CH+k] is channel k, node[i] = node[2i] + node[2i+1]
    logic [31:0]   node [1:2*NUM_CH-1];
    logic [31:0]   biased, slope;
    logic [LAT-1:0] vld_d, vld_q;
    logic [CW-1:0] col_d, col_q, row_d, row_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_leaf
        assign node[NUM_CH+k] = data_in[DATA_WIDTH*k +: DATA_WIDTH];
    end

    for (genvar i = 1; i < NUM_CH; i++) begin : g_tree
        fp32_add_reg u_add (
            .Clk (Clk),
            .Rst (Rst),
            .a   (node[2*i]),
            .b   (node[2*i+1]),
            .y   (node[i])
        );
    end

    fp32_add_reg u_bias (
        .Clk (Clk),
        .Rst (Rst),
        .a   (node[1]),
        .b   (BIAS),
        .y   (biased)
    );

    // positive values are multiplied by exactly 1.0, which returns them unchanged
    assign slope = biased[31] ? LEAKY_SLOPE : ONE;

    fp32_mul_reg u_leaky (
        .Clk (Clk),
        .Rst (Rst),
        .a   (biased),
        .b   (slope),
        .y   (data_out)
    );

    assign valid_out = vld_q[LAT-1];
    assign row_end   = valid_out && col_q == CW'(IMG_SIZE - 1);
    assign frame_end = row_end && row_q == CW'(IMG_SIZE - 1);

    always_comb begin
        vld_d = {vld_q[LAT-2:0], valid_in};
        col_d = !valid_out ? col_q : row_end ? '0 : col_q + CW'(1);
        row_d = !row_end ? row_q : frame_end ? '0 : row_q + CW'(1);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            vld_q <= vld_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: tb/tb_layer_4_featuremap_reduce.sv
// tb_layer_4_featuremap_reduce: directed vectors with a queued scoreboard; a 4x4-frame DUT with
// zero bias and a second DUT with bias -64.0.
module tb_layer_4_featuremap_reduce;
    localparam logic [31:0] F1 = 32'h3F800000;

    typedef struct {
        logic [31:0] data;
        logic        re;
        logic        fe;
        int          cyc;
    } exp_t;

    logic          Clk, Rst;
    logic [1023:0] data_in;
    logic          valid_in, valid_in_b;
    logic [31:0]   data_out, data_out_b;
    logic          valid_out, row_end, frame_end;
    logic          valid_out_b, row_end_b, frame_end_b;

    exp_t          q[$], qb[$];
    exp_t          ea, eb;
    int            checks = 0, errors = 0, cyc = 0, out_n = 0;
    logic [1023:0] vec [5];
    logic [31:0]   res [5];
    logic [31:0]   nf [10] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    layer_4_featuremap_reduce #(.IMG_SIZE(4), .BIAS(32'h00000000)) u_dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .row_end   (row_end),
        .frame_end (frame_end)
    );

    layer_4_featuremap_reduce #(.BIAS(32'hC2800000)) u_dut_b (
        .Clk       (Clk),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in_b),
        .data_out  (data_out_b),
        .valid_out (valid_out_b),
        .row_end   (row_end_b),
        .frame_end (frame_end_b)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] put(input logic [1023:0] v, input int k, input logic [31:0] x);
        v[32*k +: 32] = x;
        return v;
    endfunction

    task automatic send(input logic [1023:0] v, input logic [31:0] e, input bit to_b);
        @(negedge Clk);
        data_in = v;
        valid_in = !to_b;
        valid_in_b = to_b;
        if (to_b) qb.push_back(exp_t'{e, 1'b0, 1'b0, cyc + 7});
        else begin
            q.push_back(exp_t'{e, (out_n % 4) == 3, (out_n % 16) == 15, cyc + 7});
            out_n++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            valid_in = 0;
            valid_in_b = 0;
        end
    endtask

    always @(negedge Clk) begin
        if (valid_out) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_a actual=%h expected=none", data_out);
            end else begin
                ea = q.pop_front();
                chk("data_a", data_out, ea.data);
                chk("flags_a", {30'b0, row_end, frame_end}, {30'b0, ea.re, ea.fe});
                chk("cycle_a", cyc, ea.cyc);
            end
        end
    end

    always @(negedge Clk) begin
        if (valid_out_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_b actual=%h expected=none", data_out_b);
            end else begin
                eb = qb.pop_front();
                chk("data_b", data_out_b, eb.data);
                chk("flags_b", {30'b0, row_end_b, frame_end_b}, 32'b0);
                chk("cycle_b", cyc, eb.cyc);
            end
        end
    end

    initial begin
        vec[0] = {32{F1}};                                   res[0] = 32'h42000000;
        vec[1] = {32{32'hBF800000}};                         res[1] = 32'hC04CCCCD;
        vec[2] = put(put('0, 0, 32'h40000000), 31, F1);      res[2] = 32'h40400000;
        vec[3] = put(put('0, 3, 32'h3FC00000), 4, 32'h3E800000); res[3] = 32'h3FE00000;
        vec[4] = put(put('0, 0, F1), 1, 32'h33800001);       res[4] = 32'h3F800001;
        Rst = 0;
        data_in = '0;
        valid_in = 0;
        valid_in_b = 0;
        repeat (3) @(negedge Clk);
        chk("rst_data", data_out, 32'h0);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_flags", {30'b0, row_end, frame_end}, 32'h0);
        chk("rst_valid_b", {31'b0, valid_out_b}, 32'h0);
        Rst = 1;
        idle(2);
        send(vec[0], res[0], 0);
        idle(10);
        send({32{F1}}, 32'hC04CCCCD, 1);
        send({32{32'h40000000}}, 32'h00000000, 1);
        send({32{32'h40400000}}, 32'h42000000, 1);
        idle(10);
        for (int n = 0; n < 10; n++) send(put('0, 0, nf[n]), nf[n], 0);
        idle(10);
        data_in = {32{F1}};
        idle(8);
        for (int n = 0; n < 3; n++) send({32{F1}}, 32'h42000000, 0);
        idle(2);
        chk("pre_rst_data", data_out, 32'h42000000);
        #2 Rst = 0;
        #1;
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_valid", {31'b0, valid_out}, 32'h0);
        chk("midrst_flags", {30'b0, row_end, frame_end}, 32'h0);
        q.delete();
        out_n = 0;
        repeat (2) @(negedge Clk);
        Rst = 1;
        idle(3);
        for (int n = 0; n < 20; n++) begin
            send(vec[n % 5], res[n % 5], 0);
            idle(int'($urandom_range(2)));
        end
        idle(1);
        send(put({32{F1}}, 5, 32'h7F800001), 32'h7FC00000, 0);
        send(put(put('0, 0, 32'h7F800000), 1, 32'hFF800000), 32'h7FC00000, 0);
        send({32{32'h00000001}}, 32'h00000000, 0);
        send(put(put('0, 0, 32'h7F7FFFFF), 1, 32'h7F7FFFFF), 32'h7F800000, 0);
        send(put(put('0, 0, 32'hFF7FFFFF), 1, 32'hFF7FFFFF), 32'hFF800000, 0);
        idle(1);
        for (int i = 0; i < 50 && (q.size() != 0 || qb.size() != 0); i++) @(negedge Clk);
        chk("drain_pending", 32'(q.size() + qb.size()), 32'h0);
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_4_featuremap_reduce.md
Name: layer_4_featuremap_reduce

Overview:
- Downstream stage of each layer-4 feature-map block.
- Takes the 32 per-input-channel FP32 3x3 convolution results for one output pixel, sums them with a fixed-order pipelined adder tree, adds the feature-map bias, and applies leaky ReLU (slope 0.1).
- Emits one FP32 activation per pixel, with row-end and frame-end markers for the layer-5 max-pool stage.

Parameters:
- NUM_CH, 32, number of input channel partial sums; power of two, tree depth = log2(NUM_CH).
- DATA_WIDTH, 32, FP32 word width.
- DATA_IN_WIDTH, 1024, NUM_CH*DATA_WIDTH.
- IMG_SIZE, 104, output feature-map width and height in pixels.
- BIAS, 32'h00000000, FP32 bias for this feature map.
- LEAKY_SLOPE, 32'h3DCCCCCD, FP32 negative-side slope (0.1).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_IN_WIDTH  channel k partial sum at [32k+31:32k].
- valid_in  in  1  data_in holds one pixel's 32 partial sums this cycle.
- data_out  out  DATA_WIDTH  FP32 activation.
- valid_out  out  1  data_out valid, single-cycle per pixel.
- row_end  out  1  high with valid_out on the last pixel of a row.
- frame_end  out  1  high with valid_out on the last pixel of the frame.

Behaviour:
- Reset (Rst=0, async): all pipeline data registers cleared to 0, valid shift chain cleared, column/row counters cleared. data_out=0, valid_out=0, row_end=0, frame_end=0.
- No back-pressure. Accepts one pixel every cycle valid_in=1; gaps allowed. Pipeline always advances; data registers load every cycle, and only the valid bit qualifies them.
- Adder tree, fixed association for bit-exactness:
  - Level 1: ch(2i)+ch(2i+1).
  - Level n: result(2i)+result(2i+1) of level n-1.
  - 5 levels for NUM_CH=32.
- Bias stage: tree_sum + BIAS.
- Leaky stage:
  - Sign bit 0: value passes unchanged.
  - Sign bit 1: value * LEAKY_SLOPE. This includes -0, which yields 0x80000000.
- Every add, and the leaky stage, is registered with 1-cycle latency. Total latency = log2(NUM_CH)+2 = 7 cycles from valid_in to valid_out.
- FP arithmetic rules:
  - IEEE-754 single, round-to-nearest-even.
  - Subnormal inputs and results flushed to signed zero.
  - Overflow gives signed infinity.
  - Any NaN operand gives 0x7FC00000.
  - inf + (-inf) gives 0x7FC00000.
- Position counters (col, row) advance only on valid_out:
  - row_end = valid_out && col==IMG_SIZE-1.
  - frame_end = row_end && row==IMG_SIZE-1.
  - After the last row_end, col wraps to 0 and row increments.
  - After frame_end, both wrap to 0.
- Reset mid-operation: in-flight pixels are discarded (no valid_out produced for them) and counters restart at pixel (0,0).

Decomposition:
- Shared package yolo_fp_pkg holds:
  - FP32 constants: QNAN 0x7FC00000, ZERO, LEAKY_SLOPE_0P1.
  - FP field widths: exponent 8, mantissa 23, bias 127.
  - A function computing tree depth from NUM_CH.
- Natural sub-modules:
  - fp32_add_reg: combinational FP32 add plus output register. NUM_CH-1+1 instances.
  - fp32_mul_reg: same structure for multiply, used in the leaky stage.
- The valid shift chain and counters live in the top block.

Test Plan:
- All 32 channels 0x3F800000 (1.0), BIAS=0, one valid_in pulse -> exactly one valid_out 7 cycles later, data_out=0x42000000 (32.0).
- All channels 1.0, BIAS=0xC2800000 (-64.0) -> pre-activation -32.0, data_out=0xC04CCCCD (-3.2).
- Back-to-back valid_in for 10 cycles with channel 0 = n.0 and other channels 0 -> 10 consecutive valid_out, in order, carrying 0.0..9.0, with no bubbles.
- IMG_SIZE=4, 16 pixels with random gaps in valid_in:
  - row_end on outputs 4, 8, 12, 16.
  - frame_end only on output 16.
  - 17th pixel reports as col 0 / row 0 (row_end on output 20).
- NaN on channel 5 -> 0x7FC00000. 0x7F800000 on channel 0 with 0xFF800000 on channel 1 -> 0x7FC00000. Subnormal 0x00000001 on all channels -> 0x00000000.
- Assert Rst=0 asynchronously with 3 pixels in flight -> outputs and flags go to 0 immediately, no valid_out afterwards for those pixels, and the next frame's row_end lands on output IMG_SIZE.
